// File: rtl/at24c02_pkg.sv
// Shared definitions for the AT24C02 BIST sequencer:
// FSM state codes, device constants and time conversion.
package at24c02_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_WR_REQ  = 3'd1;
    localparam state_t S_WR_WAIT = 3'd2;
    localparam state_t S_WR_TWR  = 3'd3;
    localparam state_t S_RD_REQ  = 3'd4;
    localparam state_t S_RD_WAIT = 3'd5;
    localparam state_t S_DONE    = 3'd6;

    localparam int AT24C02_SIZE = 256;

    localparam logic [6:0] AT24C02_DEV_ADDR = 7'b1010_000;

    // Microseconds to clock cycles, never less than one cycle.
    function automatic logic [31:0] us_to_cycles(
        input int clk_hz,
        input int t_us
    );
        longint cyc;
        cyc = (longint'(clk_hz) * longint'(t_us)) / 64'sd1_000_000;
        if (cyc < 64'sd1) cyc = 64'sd1;
        return cyc[31:0];
    endfunction

endpackage

// File: rtl/at24c02_bist_seq_cycle_timer.sv
// Down-counting cycle timer: start loads a count,
// expired pulses once after that many cycles.
module at24c02_bist_seq_cycle_timer (
    input  logic        sclk,
    input  logic        rst,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] load,
    output logic        expired
);

    logic [31:0] cnt;
    logic        run;

    assign expired = run && (cnt == 32'd1);

    // Count down while running; start restarts from the load value.
    always_ff @(posedge sclk) begin
        if (rst || clr) begin
            cnt <= 32'd0;
            run <= 1'b0;
        end else if (start) begin
            cnt <= (load == 32'd0) ? 32'd1 : load;
            run <= 1'b1;
        end else if (run) begin
            if (cnt == 32'd1) begin
                run <= 1'b0;
            end else begin
                cnt <= cnt - 32'd1;
            end
        end
    end

endmodule

// File: rtl/at24c02_bist_seq.sv
// Write/readback BIST sequencer driving the AT24C02 I2C byte engine.
// Writes addr^SEED to a run of cells, waits tWR per write, then verifies.
module at24c02_bist_seq
    import at24c02_pkg::*;
#(
    parameter int         SYS_CLK_FREQ = 50_000_000,
    parameter int         T_WR_US      = 5_000,
    parameter logic [6:0] DEV_ADDR     = AT24C02_DEV_ADDR,
    parameter logic [7:0] START_ADDR   = 8'h00,
    parameter int         NUM_BYTES    = 16,
    parameter logic [7:0] SEED         = 8'hA5,
    parameter int         TIMEOUT_US   = 2_000
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       start,
    output logic [6:0] equi_addr,
    output logic [7:0] reg_addr,
    output logic [7:0] write_byte,
    output logic       write_trigger,
    output logic       read_trigger,
    input  logic       write_done,
    input  logic       read_done,
    input  logic [7:0] read_byte,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic       timeout,
    output logic [7:0] err_cnt,
    output logic [7:0] err_addr
);

    localparam logic [31:0] TWR_CYC = us_to_cycles(SYS_CLK_FREQ, T_WR_US);
    localparam logic [31:0] TO_CYC  = us_to_cycles(SYS_CLK_FREQ, TIMEOUT_US);

    localparam int NB = (NUM_BYTES > AT24C02_SIZE) ? AT24C02_SIZE :
                        (NUM_BYTES < 1) ? 1 : NUM_BYTES;

    localparam logic [7:0] LAST_IDX = 8'(NB - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  idx;
    logic [7:0]  cell_addr;
    logic        last;
    logic        mismatch;

    logic        wr_trig_nxt;
    logic        rd_trig_nxt;
    logic        tmr_start;
    logic        tmr_clr;
    logic [31:0] tmr_load;
    logic        tmr_exp;
    logic        idx_clr;
    logic        idx_inc;
    logic        err_upd;
    logic        to_set;
    logic        run_clr;
    logic        fin;

    assign equi_addr = DEV_ADDR;
    assign cell_addr = START_ADDR + idx;
    assign last      = (idx == LAST_IDX);
    assign mismatch  = (read_byte != (reg_addr ^ SEED));
    assign tmr_load  = (state == S_WR_WAIT) ? TWR_CYC : TO_CYC;

    at24c02_bist_seq_cycle_timer u_cycle_timer (
        .sclk    (sclk),
        .rst     (rst),
        .clr     (tmr_clr),
        .start   (tmr_start),
        .load    (tmr_load),
        .expired (tmr_exp)
    );

    // State register.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a done pulse takes priority over timer expiry.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_WR_REQ;
            end
            S_WR_REQ: begin
                state_nxt = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (write_done)   state_nxt = S_WR_TWR;
                else if (tmr_exp) state_nxt = S_DONE;
            end
            S_WR_TWR: begin
                if (tmr_exp) state_nxt = last ? S_RD_REQ : S_WR_REQ;
            end
            S_RD_REQ: begin
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (read_done)    state_nxt = last ? S_DONE : S_RD_REQ;
                else if (tmr_exp) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Per-state control strobes for the datapath and timer.
    always_comb begin
        wr_trig_nxt = 1'b0;
        rd_trig_nxt = 1'b0;
        tmr_start   = 1'b0;
        tmr_clr     = 1'b0;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        err_upd     = 1'b0;
        to_set      = 1'b0;
        run_clr     = 1'b0;
        fin         = 1'b0;
        unique case (state)
            S_IDLE: begin
                tmr_clr = 1'b1;
                if (start) begin
                    run_clr = 1'b1;
                    idx_clr = 1'b1;
                end
            end
            S_WR_REQ: begin
                wr_trig_nxt = 1'b1;
                tmr_start   = 1'b1;
            end
            S_WR_WAIT: begin
                if (write_done) tmr_start = 1'b1;
                else if (tmr_exp) to_set = 1'b1;
            end
            S_WR_TWR: begin
                if (tmr_exp) begin
                    idx_clr = last;
                    idx_inc = !last;
                end
            end
            S_RD_REQ: begin
                rd_trig_nxt = 1'b1;
                tmr_start   = 1'b1;
            end
            S_RD_WAIT: begin
                if (read_done) begin
                    err_upd = mismatch;
                    idx_inc = !last;
                end else if (tmr_exp) begin
                    to_set = 1'b1;
                end
            end
            S_DONE: begin
                fin     = 1'b1;
                tmr_clr = 1'b1;
            end
            default: begin
                tmr_clr = 1'b1;
            end
        endcase
    end

    // Registered engine interface, cell index and run status.
    always_ff @(posedge sclk) begin
        if (rst) begin
            reg_addr      <= START_ADDR;
            write_byte    <= 8'h00;
            write_trigger <= 1'b0;
            read_trigger  <= 1'b0;
            idx           <= 8'h00;
            busy          <= 1'b0;
            pass          <= 1'b0;
            fail          <= 1'b0;
            timeout       <= 1'b0;
            err_cnt       <= 8'h00;
            err_addr      <= 8'h00;
        end else begin
            write_trigger <= wr_trig_nxt;
            read_trigger  <= rd_trig_nxt;
            if (wr_trig_nxt || rd_trig_nxt) begin
                reg_addr <= cell_addr;
            end
            if (wr_trig_nxt) begin
                write_byte <= cell_addr ^ SEED;
            end
            if (idx_clr) begin
                idx <= 8'h00;
            end else if (idx_inc) begin
                idx <= idx + 8'h01;
            end
            if (run_clr) begin
                busy     <= 1'b1;
                pass     <= 1'b0;
                fail     <= 1'b0;
                timeout  <= 1'b0;
                err_cnt  <= 8'h00;
                err_addr <= 8'h00;
            end
            if (err_upd) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
                if (err_cnt == 8'h00) err_addr <= reg_addr;
            end
            if (to_set) begin
                timeout <= 1'b1;
            end
            if (fin) begin
                busy <= 1'b0;
                pass <= (err_cnt == 8'h00) && !timeout;
                fail <= !((err_cnt == 8'h00) && !timeout);
            end
        end
    end

endmodule

// File: tb/tb_at24c02_bist_seq.sv
// Bench for at24c02_bist_seq: two instances (base 00 and FE)
// against a behavioural I2C engine with a 256-byte memory.
module tb_at24c02_bist_seq;

    localparam logic [7:0] SEED = 8'hA5;
    localparam int         NB   = 4;

    logic             sclk = 1'b0;
    logic             rst  = 1'b1;
    logic [1:0]       start = 2'b00;
    logic [1:0][6:0]  equi_addr;
    logic [1:0][7:0]  reg_addr;
    logic [1:0][7:0]  write_byte;
    logic [1:0][7:0]  err_cnt;
    logic [1:0][7:0]  err_addr;
    logic [1:0][7:0]  rbyte;
    logic [1:0]       wtrig, rtrig, wdone, rdone;
    logic [1:0]       busy, pass, fail, tmo;

    logic [7:0] mem     [2][256];
    logic [7:0] corrupt [2][256];
    bit         drop_rd [2];
    bit         stray_en[2];
    int         ecnt    [2];
    logic       e_rd    [2];
    logic [7:0] e_a     [2];
    logic [7:0] e_d     [2];
    int         wn      [2];
    int         rn      [2];
    int         overlap [2];
    int         both_hi [2];
    logic [7:0] wlog_a  [2][64];
    logic [7:0] wlog_d  [2][64];
    logic [7:0] rlog_a  [2][64];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 sclk = ~sclk;

    at24c02_bist_seq #(
        .SYS_CLK_FREQ (50_000_000),
        .T_WR_US      (1),
        .DEV_ADDR     (7'b1010_000),
        .START_ADDR   (8'h00),
        .NUM_BYTES    (NB),
        .SEED         (SEED),
        .TIMEOUT_US   (10)
    ) dut0 (
        .sclk          (sclk),
        .rst           (rst),
        .start         (start[0]),
        .equi_addr     (equi_addr[0]),
        .reg_addr      (reg_addr[0]),
        .write_byte    (write_byte[0]),
        .write_trigger (wtrig[0]),
        .read_trigger  (rtrig[0]),
        .write_done    (wdone[0]),
        .read_done     (rdone[0]),
        .read_byte     (rbyte[0]),
        .busy          (busy[0]),
        .pass          (pass[0]),
        .fail          (fail[0]),
        .timeout       (tmo[0]),
        .err_cnt       (err_cnt[0]),
        .err_addr      (err_addr[0])
    );

    at24c02_bist_seq #(
        .SYS_CLK_FREQ (50_000_000),
        .T_WR_US      (1),
        .DEV_ADDR     (7'b1010_000),
        .START_ADDR   (8'hFE),
        .NUM_BYTES    (NB),
        .SEED         (SEED),
        .TIMEOUT_US   (10)
    ) dut1 (
        .sclk          (sclk),
        .rst           (rst),
        .start         (start[1]),
        .equi_addr     (equi_addr[1]),
        .reg_addr      (reg_addr[1]),
        .write_byte    (write_byte[1]),
        .write_trigger (wtrig[1]),
        .read_trigger  (rtrig[1]),
        .write_done    (wdone[1]),
        .read_done     (rdone[1]),
        .read_byte     (rbyte[1]),
        .busy          (busy[1]),
        .pass          (pass[1]),
        .fail          (fail[1]),
        .timeout       (tmo[1]),
        .err_cnt       (err_cnt[1]),
        .err_addr      (err_addr[1])
    );

    // Engine model: done 20 cycles after a trigger, logs every request.
    always @(posedge sclk) begin
        for (int k = 0; k < 2; k++) begin
            wdone[k] <= 1'b0;
            rdone[k] <= 1'b0;
            assert (!(wtrig[k] && rtrig[k]));
            if (wtrig[k] && rtrig[k]) both_hi[k] <= both_hi[k] + 1;
            if (ecnt[k] != 0) begin
                ecnt[k] <= ecnt[k] - 1;
                if (ecnt[k] == 10 && e_rd[k] && stray_en[k]) begin
                    wdone[k] <= 1'b1;
                end
                if (ecnt[k] == 1) begin
                    if (e_rd[k]) begin
                        if (!drop_rd[k]) begin
                            rdone[k] <= 1'b1;
                            rbyte[k] <= mem[k][e_a[k]];
                        end
                    end else begin
                        mem[k][e_a[k]] <= e_d[k] ^ corrupt[k][e_a[k]];
                        wdone[k] <= 1'b1;
                    end
                end
            end
            if (wtrig[k] || rtrig[k]) begin
                if (ecnt[k] != 0) overlap[k] <= overlap[k] + 1;
                ecnt[k] <= 20;
                e_rd[k] <= rtrig[k];
                e_a[k]  <= reg_addr[k];
                e_d[k]  <= write_byte[k];
                if (wtrig[k]) begin
                    wlog_a[k][wn[k] % 64] <= reg_addr[k];
                    wlog_d[k][wn[k] % 64] <= write_byte[k];
                    wn[k] <= wn[k] + 1;
                end else begin
                    rlog_a[k][rn[k] % 64] <= reg_addr[k];
                    rn[k] <= rn[k] + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] base_addr(input int k);
        return (k == 0) ? 8'h00 : 8'hFE;
    endfunction

    task automatic chk_rst(input int k);
        chk("rst_busy",  32'(busy[k]), 32'd0);
        chk("rst_pass",  32'(pass[k]), 32'd0);
        chk("rst_fail",  32'(fail[k]), 32'd0);
        chk("rst_tmo",   32'(tmo[k]), 32'd0);
        chk("rst_ecnt",  32'(err_cnt[k]), 32'd0);
        chk("rst_eaddr", 32'(err_addr[k]), 32'd0);
        chk("rst_wbyte", 32'(write_byte[k]), 32'd0);
        chk("rst_wtrig", 32'(wtrig[k]), 32'd0);
        chk("rst_rtrig", 32'(rtrig[k]), 32'd0);
        chk("rst_raddr", 32'(reg_addr[k]), 32'(base_addr(k)));
        chk("rst_dev",   32'(equi_addr[k]), 32'h50);
    endtask

    // One full test run, checked against the expected cell sequence.
    task automatic run(input int k, input bit mid);
        int         wb, rb, nerr, nrd;
        logic [7:0] a, first;
        bit         ended;
        wb = wn[k];
        rb = rn[k];
        @(negedge sclk) start[k] = 1'b1;
        @(negedge sclk) start[k] = 1'b0;
        chk("busy_set", 32'(busy[k]), 32'd1);
        chk("wtrig_early", 32'(wtrig[k]), 32'd0);
        @(negedge sclk);
        chk("wtrig_lat", 32'(wtrig[k]), 32'd1);
        ended = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge sclk);
            start[k] = mid && (c == 100);
            if (!busy[k]) begin
                ended = 1'b1;
                break;
            end
        end
        start[k] = 1'b0;
        chk("run_end", 32'(ended), 32'd1);
        nerr  = 0;
        first = 8'h00;
        if (!drop_rd[k]) begin
            for (int i = 0; i < NB; i++) begin
                a = base_addr(k) + 8'(i);
                if (corrupt[k][a] != 8'h00) begin
                    if (nerr == 0) first = a;
                    nerr++;
                end
            end
        end
        nrd = drop_rd[k] ? 1 : NB;
        chk("pass", 32'(pass[k]), 32'(nerr == 0 && !drop_rd[k]));
        chk("fail", 32'(fail[k]), 32'(nerr != 0 || drop_rd[k]));
        chk("timeout", 32'(tmo[k]), 32'(drop_rd[k]));
        chk("err_cnt", 32'(err_cnt[k]), 32'(nerr));
        chk("err_addr", 32'(err_addr[k]), 32'(first));
        chk("n_writes", 32'(wn[k] - wb), 32'(NB));
        chk("n_reads", 32'(rn[k] - rb), 32'(nrd));
        for (int i = 0; i < NB; i++) begin
            a = base_addr(k) + 8'(i);
            chk("wr_addr", 32'(wlog_a[k][(wb + i) % 64]), 32'(a));
            chk("wr_data", 32'(wlog_d[k][(wb + i) % 64]), 32'(a ^ SEED));
        end
        for (int i = 0; i < nrd; i++) begin
            a = base_addr(k) + 8'(i);
            chk("rd_addr", 32'(rlog_a[k][(rb + i) % 64]), 32'(a));
        end
    endtask

    initial begin
        int  k, tb0;
        bit  got;
        logic [7:0] a;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 256; i++) corrupt[j][i] = 8'h00;
        end
        repeat (3) @(negedge sclk);
        chk_rst(0);
        chk_rst(1);
        rst = 1'b0;
        @(negedge sclk);

        run(0, 1'b0);
        corrupt[0][8'h02] = 8'hA7;
        run(0, 1'b0);
        chk("cell02_err", 32'(err_addr[0]), 32'h02);
        corrupt[0][8'h02] = 8'h00;
        run(1, 1'b0);
        drop_rd[1] = 1'b1;
        run(1, 1'b0);
        drop_rd[1] = 1'b0;
        run(1, 1'b0);
        stray_en[0] = 1'b1;
        run(0, 1'b1);
        stray_en[0] = 1'b0;

        for (int r = 0; r < 6; r++) begin
            k = int'($urandom_range(0, 1));
            for (int i = 0; i < NB; i++) begin
                a = base_addr(k) + 8'(i);
                corrupt[k][a] = ($urandom_range(0, 1) == 1) ?
                                8'($urandom_range(1, 255)) : 8'h00;
            end
            stray_en[k] = ($urandom_range(0, 1) == 1);
            run(k, ($urandom_range(0, 1) == 1));
            for (int i = 0; i < NB; i++) begin
                a = base_addr(k) + 8'(i);
                corrupt[k][a] = 8'h00;
            end
            stray_en[k] = 1'b0;
        end

        @(negedge sclk) start[0] = 1'b1;
        @(negedge sclk) start[0] = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge sclk);
            if (wdone[0]) begin
                got = 1'b1;
                break;
            end
        end
        chk("reach_twr", 32'(got), 32'd1);
        repeat (10) @(negedge sclk);
        rst = 1'b1;
        @(negedge sclk);
        rst = 1'b0;
        chk("rst_no_wtrig", 32'(wtrig[0]), 32'd0);
        chk("rst_no_rtrig", 32'(rtrig[0]), 32'd0);
        tb0 = wn[0] + rn[0];
        repeat (200) @(negedge sclk);
        chk("rst_no_trig", 32'(wn[0] + rn[0] - tb0), 32'd0);
        chk_rst(0);

        rst      = 1'b1;
        start[0] = 1'b1;
        @(negedge sclk);
        rst      = 1'b0;
        start[0] = 1'b0;
        repeat (5) @(negedge sclk);
        chk("rst_wins", 32'(busy[0]), 32'd0);
        chk("rst_wins_trig", 32'(wn[0] + rn[0] - tb0), 32'd0);
        run(0, 1'b0);

        for (int j = 0; j < 2; j++) begin
            chk("overlap", 32'(overlap[j]), 32'd0);
            chk("both_trig", 32'(both_hi[j]), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
